obi_arbiter: RTL and testbench

Two-to-one OBI arbiter that shares a single memory/bus subordinate port between the cv32e40p instruction fetch port and data port. Sits between the core and `bus` in `top`. It arbitrates address phases, keeps OBI request stability across stalled grants, and tracks outstanding transactions so that in-order `rvalid`/`rdata` responses return to the requester that issued them.

---
 rtl/obi_pkg.sv | 11 +
 rtl/obi_id_fifo.sv | 61 ++++++
 rtl/obi_arbiter.sv | 134 +++++++++++++
 tb/tb_obi_arbiter.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/obi_pkg.sv
// Shared types and constants for the OBI instruction/data arbiter.
package obi_pkg;

   typedef enum logic {
      OBI_ID_INSTR = 1'b0,
      OBI_ID_DATA  = 1'b1
   } obi_id_e;

   localparam logic [3:0] OBI_BE_FULL = 4'hF;

endpackage

// File: rtl/obi_id_fifo.sv
// Outstanding-transaction ID FIFO: remembers which requester owns each
// accepted address phase so in-order responses can be steered back.
module obi_id_fifo #(
   parameter int unsigned DEPTH = 2
) (
   input  logic clk_i,
   input  logic rst,
   input  logic push,
   input  logic pop,
   input  logic din,
   output logic head,
   output logic full,
   output logic empty
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

   logic [DEPTH-1:0] mem_q;
   logic [PTR_W-1:0] wr_ptr_q;
   logic [PTR_W-1:0] rd_ptr_q;
   logic [CNT_W-1:0] count_q;
   logic             do_push;
   logic             do_pop;

   // Explicit wrap keeps DEPTH=1 correct where the pointer is wider than needed.
   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      if (p == PTR_W'(DEPTH - 1))
         return '0;
      else
         return p + 1'b1;
   endfunction

   assign full    = (count_q == CNT_W'(DEPTH));
   assign empty   = (count_q == '0);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign head    = mem_q[rd_ptr_q];

   always_ff @(posedge clk_i or posedge rst) begin
      if (rst) begin
         mem_q    <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) begin
            mem_q[wr_ptr_q] <= din;
            wr_ptr_q        <= ptr_inc(wr_ptr_q);
         end
         if (do_pop)
            rd_ptr_q <= ptr_inc(rd_ptr_q);
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: rtl/obi_arbiter.sv
// Two-to-one OBI arbiter (instruction fetch + data) onto one subordinate port.
// OBI_ARB_ROUND_ROBIN_EN selects round-robin; OBI_ARB_ASSERT_EN adds protocol checks.
module obi_arbiter
   import obi_pkg::*;
#(
   parameter int unsigned MAX_OUTSTANDING = 2
) (
   input  logic        clk_i,
   input  logic        rst,
   input  logic        instr_req_i,
   input  logic [31:0] instr_addr_i,
   output logic        instr_gnt_o,
   output logic        instr_rvalid_o,
   output logic [31:0] instr_rdata_o,
   input  logic        data_req_i,
   input  logic        data_we_i,
   input  logic [3:0]  data_be_i,
   input  logic [31:0] data_addr_i,
   input  logic [31:0] data_wdata_i,
   output logic        data_gnt_o,
   output logic        data_rvalid_o,
   output logic [31:0] data_rdata_o,
   output logic        s_req_o,
   output logic        s_we_o,
   output logic [3:0]  s_be_o,
   output logic [31:0] s_addr_o,
   output logic [31:0] s_wdata_o,
   input  logic        s_gnt_i,
   input  logic        s_rvalid_i,
   input  logic [31:0] s_rdata_i
);

   obi_id_e winner;
   obi_id_e pref;
   obi_id_e lock_id_q;
   logic    lock_q;
   logic    any_req;
   logic    accept;
   logic    fifo_full;
   logic    fifo_empty;
   logic    fifo_head;
   logic    rvalid_ok;

`ifdef OBI_ARB_ROUND_ROBIN_EN
   obi_id_e rr_q;

   always_ff @(posedge clk_i or posedge rst) begin
      if (rst)
         rr_q <= OBI_ID_DATA;
      else if (accept)
         rr_q <= (winner == OBI_ID_DATA) ? OBI_ID_INSTR : OBI_ID_DATA;
   end

   assign pref = rr_q;
`else
   assign pref = OBI_ID_DATA;
`endif

   always_comb begin
      winner = OBI_ID_DATA;
      if (lock_q)
         winner = lock_id_q;
      else if (instr_req_i && data_req_i)
         winner = pref;
      else if (instr_req_i)
         winner = OBI_ID_INSTR;
   end

   // Full gating is absolute: a same-cycle pop does not open a slot.
   assign any_req = instr_req_i | data_req_i;
   assign s_req_o = any_req & ~fifo_full;
   assign accept  = s_req_o & s_gnt_i;

   always_comb begin
      s_we_o    = 1'b0;
      s_be_o    = '0;
      s_addr_o  = '0;
      s_wdata_o = '0;
      if (any_req) begin
         if (winner == OBI_ID_DATA) begin
            s_we_o    = data_we_i;
            s_be_o    = data_be_i;
            s_addr_o  = data_addr_i;
            s_wdata_o = data_wdata_i;
         end else begin
            s_be_o    = OBI_BE_FULL;
            s_addr_o  = instr_addr_i;
         end
      end
   end

   assign instr_gnt_o = accept & (winner == OBI_ID_INSTR);
   assign data_gnt_o  = accept & (winner == OBI_ID_DATA);

   // Hold the stalled winner so the subordinate sees a stable address phase.
   always_ff @(posedge clk_i or posedge rst) begin
      if (rst) begin
         lock_q    <= 1'b0;
         lock_id_q <= OBI_ID_INSTR;
      end else begin
         lock_q <= s_req_o & ~s_gnt_i;
         if (s_req_o & ~s_gnt_i)
            lock_id_q <= winner;
      end
   end

   obi_id_fifo #(
      .DEPTH (MAX_OUTSTANDING)
   ) u_fifo (
      .clk_i (clk_i),
      .rst   (rst),
      .push  (accept),
      .pop   (s_rvalid_i),
      .din   (winner),
      .head  (fifo_head),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   assign rvalid_ok      = s_rvalid_i & ~fifo_empty;
   assign instr_rvalid_o = rvalid_ok & (obi_id_e'(fifo_head) == OBI_ID_INSTR);
   assign data_rvalid_o  = rvalid_ok & (obi_id_e'(fifo_head) == OBI_ID_DATA);
   assign instr_rdata_o  = s_rdata_i;
   assign data_rdata_o   = s_rdata_i;

`ifdef OBI_ARB_ASSERT_EN
   always_ff @(posedge clk_i) begin
      if (!rst)
         assert (!(s_rvalid_i && fifo_empty))
            else $error("obi_arbiter: rvalid with no outstanding transaction");
   end
`endif

endmodule

// File: tb/tb_obi_arbiter.sv
// Directed self-checking bench for obi_arbiter with a response-ID scoreboard.
module tb_obi_arbiter;
   import obi_pkg::*;

   logic        clk_i = 1'b0;
   logic        rst;
   logic        instr_req_i;
   logic [31:0] instr_addr_i;
   logic        instr_gnt_o;
   logic        instr_rvalid_o;
   logic [31:0] instr_rdata_o;
   logic        data_req_i;
   logic        data_we_i;
   logic [3:0]  data_be_i;
   logic [31:0] data_addr_i;
   logic [31:0] data_wdata_i;
   logic        data_gnt_o;
   logic        data_rvalid_o;
   logic [31:0] data_rdata_o;
   logic        s_req_o;
   logic        s_we_o;
   logic [3:0]  s_be_o;
   logic [31:0] s_addr_o;
   logic [31:0] s_wdata_o;
   logic        s_gnt_i;
   logic        s_rvalid_i;
   logic [31:0] s_rdata_i;

   int errors = 0;
   int checks = 0;
   bit exp_q[$];

   always #5 clk_i = ~clk_i;

   obi_arbiter #(
      .MAX_OUTSTANDING (2)
   ) dut (
      .clk_i          (clk_i),
      .rst            (rst),
      .instr_req_i    (instr_req_i),
      .instr_addr_i   (instr_addr_i),
      .instr_gnt_o    (instr_gnt_o),
      .instr_rvalid_o (instr_rvalid_o),
      .instr_rdata_o  (instr_rdata_o),
      .data_req_i     (data_req_i),
      .data_we_i      (data_we_i),
      .data_be_i      (data_be_i),
      .data_addr_i    (data_addr_i),
      .data_wdata_i   (data_wdata_i),
      .data_gnt_o     (data_gnt_o),
      .data_rvalid_o  (data_rvalid_o),
      .data_rdata_o   (data_rdata_o),
      .s_req_o        (s_req_o),
      .s_we_o         (s_we_o),
      .s_be_o         (s_be_o),
      .s_addr_o       (s_addr_o),
      .s_wdata_o      (s_wdata_o),
      .s_gnt_i        (s_gnt_i),
      .s_rvalid_i     (s_rvalid_i),
      .s_rdata_i      (s_rdata_i)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk_i);
      #1;
   endtask

   task automatic idle();
      instr_req_i  = 1'b0;
      instr_addr_i = '0;
      data_req_i   = 1'b0;
      data_we_i    = 1'b0;
      data_be_i    = '0;
      data_addr_i  = '0;
      data_wdata_i = '0;
      s_gnt_i      = 1'b0;
      s_rvalid_i   = 1'b0;
      s_rdata_i    = '0;
   endtask

   task automatic data_rd(input logic [31:0] addr);
      data_req_i  = 1'b1;
      data_we_i   = 1'b0;
      data_be_i   = OBI_BE_FULL;
      data_addr_i = addr;
   endtask

   // Drives a response and compares routing against the oldest expected ID.
   task automatic resp(input logic [31:0] rd);
      bit id;
      s_rvalid_i = 1'b1;
      s_rdata_i  = rd;
      #1;
      if (exp_q.size() == 0) begin
         checks++;
         errors++;
         $error("FAIL scoreboard_underflow observed=empty expected=entry");
      end else begin
         id = exp_q.pop_front();
         chk("instr_rvalid", {31'b0, instr_rvalid_o}, {31'b0, ~id});
         chk("data_rvalid",  {31'b0, data_rvalid_o},  {31'b0, id});
         chk("instr_rdata",  instr_rdata_o, rd);
         chk("data_rdata",   data_rdata_o,  rd);
      end
   endtask

   initial begin
      idle();
      rst = 1'b1;
      #2;
      chk("rst_s_req",     {31'b0, s_req_o}, 32'd0);
      chk("rst_s_addr",    s_addr_o, 32'd0);
      chk("rst_s_be",      {28'b0, s_be_o}, 32'd0);
      chk("rst_gnts",      {30'b0, instr_gnt_o, data_gnt_o}, 32'd0);
      chk("rst_rvalids",   {30'b0, instr_rvalid_o, data_rvalid_o}, 32'd0);
      chk("rst_count",     32'(dut.u_fifo.count_q), 32'd0);
      cyc();
      cyc();
      rst = 1'b0;

      // Contention at reset release.
      instr_req_i  = 1'b1;
      instr_addr_i = 32'h100;
      data_rd(32'h200);
      s_gnt_i = 1'b1;
      #1;
      chk("c1_data_gnt",  {31'b0, data_gnt_o}, 32'd1);
      chk("c1_instr_gnt", {31'b0, instr_gnt_o}, 32'd0);
      chk("c1_s_addr",    s_addr_o, 32'h200);
      exp_q.push_back(1'b1);
      cyc();
`ifdef OBI_ARB_ROUND_ROBIN_EN
      chk("c2_instr_gnt", {31'b0, instr_gnt_o}, 32'd1);
      chk("c2_s_addr",    s_addr_o, 32'h100);
      exp_q.push_back(1'b0);
`else
      chk("c2_data_gnt",  {31'b0, data_gnt_o}, 32'd1);
      chk("c2_instr_gnt", {31'b0, instr_gnt_o}, 32'd0);
      exp_q.push_back(1'b1);
`endif
      cyc();
      chk("full_count", 32'(dut.u_fifo.count_q), 32'd2);

      // Full stall: third request waits for a slot.
      instr_req_i = 1'b0;
      data_rd(32'h204);
      #1;
      chk("stall1_s_req",    {31'b0, s_req_o}, 32'd0);
      chk("stall1_data_gnt", {31'b0, data_gnt_o}, 32'd0);
      cyc();
      chk("stall2_s_req", {31'b0, s_req_o}, 32'd0);
      resp(32'h11);
      chk("stall_pop_s_req",    {31'b0, s_req_o}, 32'd0);
      chk("stall_pop_data_gnt", {31'b0, data_gnt_o}, 32'd0);
      cyc();
      s_rvalid_i = 1'b0;
      #1;
      chk("unstall_s_req",    {31'b0, s_req_o}, 32'd1);
      chk("unstall_data_gnt", {31'b0, data_gnt_o}, 32'd1);
      chk("unstall_s_addr",   s_addr_o, 32'h204);
      exp_q.push_back(1'b1);
      cyc();
      idle();
      resp(32'h22);
      cyc();
      resp(32'h33);
      cyc();
      idle();
      #1;
      chk("drain_count", 32'(dut.u_fifo.count_q), 32'd0);

      // Lock across a stalled grant, then routing of two responses.
      instr_req_i  = 1'b1;
      instr_addr_i = 32'h100;
      #1;
      chk("lock1_s_req",   {31'b0, s_req_o}, 32'd1);
      chk("lock1_s_addr",  s_addr_o, 32'h100);
      chk("lock1_s_be",    {28'b0, s_be_o}, 32'hF);
      chk("lock1_s_we",    {31'b0, s_we_o}, 32'd0);
      chk("lock1_gnt",     {31'b0, instr_gnt_o}, 32'd0);
      cyc();
      data_rd(32'h200);
      data_wdata_i = 32'hDEAD_BEEF;
      #1;
      chk("lock2_s_addr",   s_addr_o, 32'h100);
      chk("lock2_s_wdata",  s_wdata_o, 32'd0);
      chk("lock2_data_gnt", {31'b0, data_gnt_o}, 32'd0);
      cyc();
      chk("lock3_s_addr", s_addr_o, 32'h100);
      cyc();
      s_gnt_i = 1'b1;
      #1;
      chk("lock_rel_instr_gnt", {31'b0, instr_gnt_o}, 32'd1);
      chk("lock_rel_data_gnt",  {31'b0, data_gnt_o}, 32'd0);
      chk("lock_rel_s_addr",    s_addr_o, 32'h100);
      exp_q.push_back(1'b0);
      cyc();
      instr_req_i = 1'b0;
      #1;
      chk("after_lock_data_gnt", {31'b0, data_gnt_o}, 32'd1);
      chk("after_lock_s_addr",   s_addr_o, 32'h200);
      exp_q.push_back(1'b1);
      cyc();
      idle();
      resp(32'hAAAA);
      cyc();
      resp(32'hBBBB);
      cyc();
      idle();

      // Write pass-through, then same-cycle push and pop.
      data_req_i   = 1'b1;
      data_we_i    = 1'b1;
      data_be_i    = 4'h3;
      data_addr_i  = 32'h300;
      data_wdata_i = 32'hCAFE_F00D;
      s_gnt_i      = 1'b1;
      #1;
      chk("wr_s_we",    {31'b0, s_we_o}, 32'd1);
      chk("wr_s_be",    {28'b0, s_be_o}, 32'h3);
      chk("wr_s_wdata", s_wdata_o, 32'hCAFE_F00D);
      exp_q.push_back(1'b1);
      cyc();
      idle();
      instr_req_i  = 1'b1;
      instr_addr_i = 32'h108;
      s_gnt_i      = 1'b1;
      exp_q.push_back(1'b0);
      resp(32'h0);
      chk("pp_instr_gnt", {31'b0, instr_gnt_o}, 32'd1);
      cyc();
      idle();
      #1;
      chk("pp_count", 32'(dut.u_fifo.count_q), 32'd1);
      chk("pp_head",  {31'b0, dut.u_fifo.head}, 32'd0);
      resp(32'h44);
      cyc();
      idle();
      #1;
      chk("pp_drain_count", 32'(dut.u_fifo.count_q), 32'd0);

      // Reset with two transactions in flight.
      data_rd(32'h400);
      s_gnt_i = 1'b1;
      cyc();
      cyc();
      idle();
      #1;
      chk("mid_count", 32'(dut.u_fifo.count_q), 32'd2);
      rst = 1'b1;
      #1;
      chk("mid_rst_count", 32'(dut.u_fifo.count_q), 32'd0);
      cyc();
      rst = 1'b0;
      s_rvalid_i = 1'b1;
      s_rdata_i  = 32'h55;
      #1;
      chk("stray_rvalids", {30'b0, instr_rvalid_o, data_rvalid_o}, 32'd0);
      cyc();
      idle();
      #1;
      chk("stray_count", 32'(dut.u_fifo.count_q), 32'd0);
      chk("scoreboard_left", 32'(exp_q.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
